frame_mem_arbiter: RTL

//  Shares the single-port image RAM between two requesters.
//  - Display pixel fetch: read-only, fixed priority.
//  - Filter engine: read/write, valid/ready handshake.

---
 rtl/frame_mem_pkg.sv | 25 ++
 rtl/frame_mem_tag_pipe.sv | 28 ++
 rtl/frame_mem_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_mem_pkg.sv
// Shared types and constants for the frame memory arbiter.
// Optional statistics counters in the arbiter are enabled by FRAME_MEM_ARB_STATS_EN.
package frame_mem_pkg;

  localparam int IMG_W      = 100;
  localparam int IMG_H      = 100;
  localparam int IMG_WORDS  = IMG_W * IMG_H;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;

  // Owner of a RAM read travelling down the return pipe
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_FLT  = 2'd2
  } owner_t;

  // Filter write path state
  typedef enum logic {
    IDLE     = 1'b0,
    WR_ISSUE = 1'b1
  } wrState_t;

endpackage

// File: rtl/frame_mem_tag_pipe.sv
// Owner-tag shift register that tracks reads in flight through the RAM.
// Depth is the number of cycles from grant to the cycle mem_q holds the data.
module frame_mem_tag_pipe
  import frame_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t tag_i,
  output owner_t tag_o
);

  owner_t stage_q [DEPTH];

  // Shift tags one stage per cycle; reset flushes every in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_mem_arbiter.sv
// Shares the single-port image RAM between the display fetch (fixed priority,
// read-only) and the filter engine (valid/ready, read/write). A starvation
// guard forces a filter slot after STARVE_MAX cycles of waiting.
// Define FRAME_MEM_ARB_STATS_EN to add grant/miss statistics counters.
module frame_mem_arbiter
  import frame_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic              disp_miss,
  input  logic              flt_valid,
  output logic              flt_ready,
  input  logic              flt_we,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [DATA_W-1:0] flt_wdata,
  output logic [DATA_W-1:0] flt_rdata,
  output logic              flt_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
`ifdef FRAME_MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_disp_grants,
  output logic [31:0]       stat_flt_grants,
  output logic [31:0]       stat_disp_miss
`endif
);

  localparam int              WAIT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

  logic              starve;
  logic              dispGrant;
  logic              fltGrant;
  logic              dispDrop;
  owner_t            tagIn;
  owner_t            tagOut;

  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  wrState_t          wrState_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic              memWren_q;
  logic [RD_LAT-1:0] missPipe_q;
  logic              dispMiss_q;
  logic              dispRvalid_q, fltRvalid_q;
  logic [DATA_W-1:0] dispRdata_q, fltRdata_q;

  // Grant decision; flt_ready depends only on flt_valid, disp_req and the wait count
  always_comb begin
    starve    = flt_valid && (waitCnt_q == WAIT_MAX);
    fltGrant  = flt_valid && (!disp_req || starve);
    dispGrant = disp_req && !starve;
    dispDrop  = disp_req && starve;
  end

  assign flt_ready = fltGrant;

  // Owner tag entering the return pipe; filter writes return nothing
  always_comb begin
    tagIn = TAG_NONE;
    if (fltGrant) begin
      tagIn = flt_we ? TAG_NONE : TAG_FLT;
    end else if (dispGrant) begin
      tagIn = TAG_DISP;
    end
  end

  // Wait count: clears when the filter is served or idle, saturates at the limit
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!flt_valid || fltGrant) begin
      waitCnt_d = '0;
    end else if (waitCnt_q != WAIT_MAX) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) waitCnt_q <= '0;
    else        waitCnt_q <= waitCnt_d;
  end

  // Register the granted address/data; address holds when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else if (fltGrant) begin
      memAddr_q  <= flt_addr;
      memWdata_q <= flt_wdata;
    end else if (dispGrant) begin
      memAddr_q  <= disp_addr;
    end
  end

  // Filter write FSM; WR_ISSUE is the cycle the write strobe is on the RAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrState_q <= IDLE;
      memWren_q <= 1'b0;
    end else begin
      case (wrState_q)
        IDLE: begin
          if (fltGrant && flt_we) begin
            wrState_q <= WR_ISSUE;
            memWren_q <= 1'b1;
          end else begin
            memWren_q <= 1'b0;
          end
        end
        WR_ISSUE: begin
          if (fltGrant && flt_we) begin
            wrState_q <= WR_ISSUE;
            memWren_q <= 1'b1;
          end else begin
            wrState_q <= IDLE;
            memWren_q <= 1'b0;
          end
        end
        default: begin
          wrState_q <= IDLE;
          memWren_q <= 1'b0;
        end
      endcase
    end
  end

  frame_mem_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tagIn),
    .tag_o (tagOut)
  );

  // Delay a dropped display request so its miss pulse lands in the slot mem_q would have had
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      missPipe_q <= '0;
      dispMiss_q <= 1'b0;
    end else begin
      missPipe_q[0] <= dispDrop;
      for (int i = 1; i < RD_LAT; i++) missPipe_q[i] <= missPipe_q[i-1];
      dispMiss_q <= missPipe_q[RD_LAT-1];
    end
  end

  // Capture returning data for its owner; rdata holds until the next valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispRvalid_q <= 1'b0;
      fltRvalid_q  <= 1'b0;
      dispRdata_q  <= '0;
      fltRdata_q   <= '0;
    end else begin
      dispRvalid_q <= (tagOut == TAG_DISP);
      fltRvalid_q  <= (tagOut == TAG_FLT);
      if (tagOut == TAG_DISP) dispRdata_q <= mem_q;
      if (tagOut == TAG_FLT)  fltRdata_q  <= mem_q;
    end
  end

  assign mem_addr    = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign mem_wren    = memWren_q;
  assign disp_miss   = dispMiss_q;
  assign disp_rvalid = dispRvalid_q;
  assign disp_rdata  = dispRdata_q;
  assign flt_rvalid  = fltRvalid_q;
  assign flt_rdata   = fltRdata_q;

`ifdef FRAME_MEM_ARB_STATS_EN
  logic [31:0] statDisp_q, statFlt_q, statMiss_q;

  // Wrap-around event counters, counted at grant time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statDisp_q <= '0;
      statFlt_q  <= '0;
      statMiss_q <= '0;
    end else begin
      if (dispGrant) statDisp_q <= statDisp_q + 32'd1;
      if (fltGrant)  statFlt_q  <= statFlt_q + 32'd1;
      if (dispDrop)  statMiss_q <= statMiss_q + 32'd1;
    end
  end

  assign stat_disp_grants = statDisp_q;
  assign stat_flt_grants  = statFlt_q;
  assign stat_disp_miss   = statMiss_q;
`endif

endmodule
